// File: rtl/pwm_secuenciador_if.sv
// pwm_secuenciador_if
//   Configuration bus used to load the duty table of pwm_secuenciador.
//   master : the configuration/control logic that writes table entries
//   slave  : the scheduler that owns the table
// Signals
//   cfg_we    master -> slave  table write strobe
//   cfg_addr  master -> slave  table write address (AW bits)
//   cfg_data  master -> slave  duty word to store (R bits)
//   cfg_rej   slave -> master  1-clk pulse, write refused (busy or bad address)
interface pwm_secuenciador_if #(
   parameter int R     = 6,
   parameter int STEPS = 36
) ();
   localparam int AW = $clog2(STEPS);

   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [R-1:0]  cfg_data;
   logic          cfg_rej;

   modport master (output cfg_we, output cfg_addr, output cfg_data, input cfg_rej);
   modport slave  (input cfg_we, input cfg_addr, input cfg_data, output cfg_rej);
endinterface

// File: rtl/pwm_secuenciador.sv
// pwm_secuenciador
//   Duty-cycle scheduler for an R-bit PWM core. Holds a table of STEPS duty
//   words and walks through it, keeping each word for hold_count PWM periods.
//   Every duty change is aligned to the PWM counter wrap (period_end) so a
//   PWM period never carries two duty values.
// Ports
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   cfg          table write bus (slave side): cfg_we/cfg_addr/cfg_data, cfg_rej
//   start        1-clk pulse, begin a sequence (only accepted in IDLE)
//   stop         1-clk pulse, end the sequence at the next period boundary
//   loop_en      wrap to step 0 after the last step (sampled on start)
//   hold_count   PWM periods per step (sampled on start, 0 refuses start)
//   period_end   1-clk pulse from the PWM core at its counter wrap
//   duty         duty word to the PWM core
//   duty_valid   1-clk pulse in the cycle duty takes a new value
//   step_idx     current table index
//   busy         high while aligning or running
//   done         1-clk pulse when a sequence ends (one-shot end or stop)
module pwm_secuenciador #(
   parameter int R      = 6,
   parameter int STEPS  = 36,
   parameter int HOLD_W = 16,
   localparam int AW    = $clog2(STEPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   pwm_secuenciador_if.slave   cfg,
   input  logic                start,
   input  logic                stop,
   input  logic                loop_en,
   input  logic [HOLD_W-1:0]   hold_count,
   input  logic                period_end,
   output logic [R-1:0]        duty,
   output logic                duty_valid,
   output logic [AW-1:0]       step_idx,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t              state_r;
   logic [R-1:0]        table_r [STEPS];
   logic [HOLD_W-1:0]   cnt_r;
   logic [HOLD_W-1:0]   hold_r;
   logic                loop_r;
   logic                stop_pend_r;

   logic                wr_ok_s;
   logic                step_end_s;
   logic                last_step_s;
   logic                finish_s;
   logic [AW-1:0]       next_idx_s;

   // Write acceptance, step bookkeeping and the "sequence ends on this edge" decision
   always_comb begin
      // Address compare is one bit wider so STEPS == 2**AW still works
      wr_ok_s     = cfg.cfg_we && (state_r == IDLE) &&
                    ({1'b0, cfg.cfg_addr} < (AW+1)'(STEPS));
      // hold_r is never 0 outside IDLE, so hold_r-1 cannot underflow while used
      step_end_s  = (cnt_r >= (hold_r - HOLD_W'(1)));
      last_step_s = (step_idx == AW'(STEPS - 1));
      next_idx_s  = step_idx + AW'(1);
      // A pending (or same-cycle) stop wins over any step advance on this boundary
      if ((state_r == ALIGN) || (state_r == RUN)) begin
         finish_s = period_end &&
                    (stop || stop_pend_r ||
                     ((state_r == RUN) && step_end_s && last_step_s && !loop_r));
      end else begin
         finish_s = 1'b0;
      end
   end

   // Duty table storage; no reset, the table is loaded before a sequence runs
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         table_r[cfg.cfg_addr] <= cfg.cfg_data;
      end
   end

   // Refused-write flag, one cycle after the offending strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg.cfg_rej <= 1'b0;
      end else begin
         cfg.cfg_rej <= cfg.cfg_we && !wr_ok_s;
      end
   end

   // Sequencer FSM with registered duty/step/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         duty        <= {R{1'b0}};
         duty_valid  <= 1'b0;
         step_idx    <= {AW{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt_r       <= {HOLD_W{1'b0}};
         hold_r      <= {HOLD_W{1'b0}};
         loop_r      <= 1'b0;
         stop_pend_r <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         done       <= 1'b0;
         if (finish_s) begin
            state_r     <= IDLE;
            duty        <= {R{1'b0}};
            duty_valid  <= 1'b1;
            done        <= 1'b1;
            step_idx    <= {AW{1'b0}};
            cnt_r       <= {HOLD_W{1'b0}};
            stop_pend_r <= 1'b0;
            busy        <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  // start together with stop, or with a zero hold, is ignored
                  if (start && !stop && (hold_count != {HOLD_W{1'b0}})) begin
                     state_r     <= ALIGN;
                     busy        <= 1'b1;
                     hold_r      <= hold_count;
                     loop_r      <= loop_en;
                     stop_pend_r <= 1'b0;
                  end
               end
               ALIGN: begin
                  if (stop) begin
                     stop_pend_r <= 1'b1;
                  end
                  if (period_end) begin
                     duty       <= table_r[{AW{1'b0}}];
                     step_idx   <= {AW{1'b0}};
                     cnt_r      <= {HOLD_W{1'b0}};
                     duty_valid <= 1'b1;
                     state_r    <= RUN;
                  end
               end
               RUN: begin
                  if (stop) begin
                     stop_pend_r <= 1'b1;
                  end
                  if (period_end) begin
                     if (!step_end_s) begin
                        cnt_r <= cnt_r + HOLD_W'(1);
                     end else begin
                        cnt_r      <= {HOLD_W{1'b0}};
                        duty_valid <= 1'b1;
                        // Reaching here on the last step means looping is enabled
                        if (last_step_s) begin
                           step_idx <= {AW{1'b0}};
                           duty     <= table_r[{AW{1'b0}}];
                        end else begin
                           step_idx <= next_idx_s;
                           duty     <= table_r[next_idx_s];
                        end
                     end
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
